tqvp_scroll_compositor: RTL and testbench
=========================================

TQVP_SCROLL_COMPOSITOR -- requirements
Module: tqvp_scroll_compositor

Interface
REQ-001 SHALL have parameter NUM_LAYERS, default 3, number of background layers composited (1..4).
REQ-002 SHALL have parameter SCROLL_W, default 11, integer scroll offset width in pixels.
REQ-003 SHALL have parameter FRAC_W, default 4, sub-pixel fraction bits of each scroll accumulator.
REQ-004 SHALL have port clk  input  1  project clock (64 MHz nominal).
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports address  input  6, data_in  input  32, data_write_n  input  2, data_read_n  input  2: TinyQV bus; 11 = idle.
REQ-007 SHALL have ports data_out  output  32, data_ready  output  1: read data, ready tied 1.
REQ-008 SHALL have port user_interrupt  output  1  level interrupt request.
REQ-009 SHALL have ports vid_hsync, vid_vsync, vid_visible  input  1 each: positive-polarity timing from the video controller.
REQ-010 SHALL have port layer_rgb  input  NUM_LAYERS*6  per-layer {B,G,R} 2-bit pixels, layer 0 in the LSBs.
REQ-011 SHALL have port scroll_x  output  NUM_LAYERS*SCROLL_W  per-layer integer scroll offset to layer generators.
REQ-012 SHALL have port uo_out  output  8  {vsync, hsync, B[1:0], G[1:0], R[1:0]}.

Function
REQ-013 SHALL decode registers: 0x00 CTRL ([0] enable, [NUM_LAYERS:1] layer enables); 0x04 STATUS (R: [15:0] frame count, [16] irq flag; W: bit16=1 clears flag); 0x08+4*i LAYERi (i<NUM_LAYERS: [7:0] signed speed in 1/2^FRAC_W px/frame, bit15 write-1 zeroes accumulator, reads 0); 0x20 KEY [5:0] transparent colour; 0x24 BGCOL [5:0] backdrop; 0x28 IRQ_PERIOD [15:0].
REQ-014 SHALL accept any write size (data_write_n != 11), using low bits of data_in; unmapped addresses SHALL ignore writes and read 0.
REQ-015 SHALL return data_out combinationally from current register state, upper unused bits 0.
REQ-016 SHALL detect frame boundary as a vid_vsync 0->1 transition (registered previous value).
REQ-017 SHALL, on each frame boundary while CTRL.enable=1, add sign-extended speed to each layer's (SCROLL_W+FRAC_W)-bit accumulator, wrapping modulo 2^(SCROLL_W+FRAC_W); scroll_x = accumulator[top SCROLL_W bits].
REQ-018 SHALL give accumulator-zero priority over a same-cycle frame-boundary update (result 0).
REQ-019 SHALL increment the 16-bit frame counter on each enabled frame boundary, wrapping 0xFFFF->0.
REQ-020 SHALL set irq flag when the frame counter increments to a non-zero multiple of IRQ_PERIOD; IRQ_PERIOD=0 disables; set SHALL win over same-cycle clear.
REQ-021 SHALL drive user_interrupt = irq flag.
REQ-022 SHALL composite per pixel: lowest-index layer that is enabled and whose pixel != KEY wins; none qualifying -> BGCOL; vid_visible=0 or CTRL.enable=0 -> 000000.
REQ-023 SHALL register uo_out with 1-cycle latency, delaying hsync/vsync by the same 1 cycle for alignment.
REQ-024 SHALL hold accumulators and frame counter while CTRL.enable=0.

Reset
REQ-025 SHALL, on rst_n low (asynchronous), clear all registers, accumulators, frame counter, irq flag, vsync history; uo_out=0, scroll_x=0, user_interrupt=0.
REQ-026 SHALL resume from reset values on the first clock after rst_n deasserts; reset mid-frame SHALL NOT generate a frame boundary unless vid_vsync later rises.

Structure
REQ-027 SHALL place register address constants, field bit positions and the 6-bit pixel typedef in shared package tqvp_scroll_pkg.
REQ-028 SHALL instantiate sub-module bg_scroll_accum once per layer (accumulator, speed register, zero/step logic).

Verification
REQ-029 Speed 0x10 (1 px/frame), enable, 5 vsync edges -> scroll_x layer0 = 5.
REQ-030 Speed 0xF8 (-0.5 px), 2 edges from 0 -> accumulator wraps, scroll_x = 0x7FF.
REQ-031 Layers 0,1 enabled, KEY=0x00, layer0=0x00, layer1=0x15, visible -> uo_out[5:0]=0x15 one cycle later; layer1=0x00 -> BGCOL.
REQ-032 IRQ_PERIOD=3, 3 edges -> user_interrupt=1; STATUS write bit16 on 6th-edge cycle -> stays 1.
REQ-033 LAYER0 bit15 write coincident with vsync rise -> scroll_x=0.
REQ-034 rst_n low mid-stream -> all outputs 0 immediately, frame count reads 0.

Source files
------------

// File: rtl/tqvp_scroll_pkg.sv
// Shared constants and types for the TinyQV scroll compositor peripheral.
package tqvp_scroll_pkg;

  // One pixel as {B[1:0], G[1:0], R[1:0]}.
  typedef logic [5:0] pixel_t;

  // Register byte addresses on the 6-bit peripheral bus.
  localparam logic [5:0] ADDR_CTRL       = 6'h00;
  localparam logic [5:0] ADDR_STATUS     = 6'h04;
  localparam logic [5:0] ADDR_LAYER0     = 6'h08;
  localparam logic [5:0] ADDR_KEY        = 6'h20;
  localparam logic [5:0] ADDR_BGCOL      = 6'h24;
  localparam logic [5:0] ADDR_IRQ_PERIOD = 6'h28;

  // Field positions.
  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_LAYER_LSB = 1;
  localparam int STATUS_IRQ_BIT = 16;
  localparam int LAYER_ZERO_BIT = 15;
  localparam int SPEED_W        = 8;
  localparam int FRAME_CNT_W    = 16;

  // Address of the per-layer speed/control register for layer idx.
  function automatic logic [5:0] layer_addr(input int idx);
    return ADDR_LAYER0 + 6'(4 * idx);
  endfunction

endpackage

// File: rtl/bg_scroll_accum.sv
// Per-layer scroll state: signed speed register and a wrapping sub-pixel
// accumulator whose integer part is the layer's horizontal scroll offset.
module bg_scroll_accum
  import tqvp_scroll_pkg::*;
#(
  parameter int SCROLL_W = 11,
  parameter int FRAC_W   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                speed_we,
  input  logic [SPEED_W-1:0]  speed_in,
  input  logic                zero,
  input  logic                step,
  output logic [SPEED_W-1:0]  speed,
  output logic [SCROLL_W-1:0] scroll
);

  localparam int ACC_W = SCROLL_W + FRAC_W;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] speed_ext;

  assign speed_ext = {{(ACC_W - SPEED_W){speed[SPEED_W-1]}}, speed};
  assign scroll    = acc[ACC_W-1 -: SCROLL_W];

  // Speed register, loaded on any write to this layer's register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) speed <= '0;
    else if (speed_we) speed <= speed_in;
  end

  // Accumulator: an explicit zero request beats the per-frame step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    acc <= '0;
    else if (zero) acc <= '0;
    else if (step) acc <= acc + speed_ext;
  end

endmodule

// File: rtl/tqvp_scroll_compositor.sv
// Multi-layer parallax scroll compositor on the TinyQV peripheral bus.
// Advances per-layer scroll offsets once per frame and picks, per pixel,
// the lowest-index enabled non-key layer over a backdrop colour.
module tqvp_scroll_compositor
  import tqvp_scroll_pkg::*;
#(
  parameter int NUM_LAYERS = 3,
  parameter int SCROLL_W   = 11,
  parameter int FRAC_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [5:0]                     address,
  input  logic [31:0]                    data_in,
  input  logic [1:0]                     data_write_n,
  input  logic [1:0]                     data_read_n,
  output logic [31:0]                    data_out,
  output logic                           data_ready,
  output logic                           user_interrupt,
  input  logic                           vid_hsync,
  input  logic                           vid_vsync,
  input  logic                           vid_visible,
  input  logic [NUM_LAYERS*6-1:0]        layer_rgb,
  output logic [NUM_LAYERS*SCROLL_W-1:0] scroll_x,
  output logic [7:0]                     uo_out
);

  logic [NUM_LAYERS:0]    ctrl;
  pixel_t                 key;
  pixel_t                 bgcol;
  logic [15:0]            irq_period;
  logic [FRAME_CNT_W-1:0] frame_cnt;
  logic                   irq;
  logic                   vsync_q;
  logic                   armed;
  logic [SPEED_W-1:0]     speed [NUM_LAYERS];

  logic                   bus_write;
  logic                   frame_edge;
  logic                   advance;
  logic [FRAME_CNT_W-1:0] cnt_next;
  logic                   irq_hit;
  logic                   irq_clear;
  pixel_t                 pix_sel;
  pixel_t                 rgb_next;
  logic                   unused_bits;

  // Reads are combinational, so the read strobe and high data bits carry no information.
  assign unused_bits = &{1'b0, data_read_n, data_in[31:17]};

  assign data_ready     = 1'b1;
  assign user_interrupt = irq;
  assign bus_write      = (data_write_n != 2'b11);

  // A frame starts on vsync rising; the first clock after reset only primes the history.
  assign frame_edge = armed & vid_vsync & ~vsync_q;
  assign advance    = frame_edge & ctrl[CTRL_EN_BIT];
  assign cnt_next   = frame_cnt + 1'b1;
  assign irq_hit    = advance && (irq_period != '0) && (cnt_next != '0)
                      && ((cnt_next % irq_period) == '0);
  assign irq_clear  = bus_write && (address == ADDR_STATUS) && data_in[STATUS_IRQ_BIT];

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
    logic sel;
    assign sel = bus_write && (address == layer_addr(i));
    bg_scroll_accum #(.SCROLL_W(SCROLL_W), .FRAC_W(FRAC_W)) u_accum (
      .clk      (clk),
      .rst_n    (rst_n),
      .speed_we (sel),
      .speed_in (data_in[SPEED_W-1:0]),
      .zero     (sel & data_in[LAYER_ZERO_BIT]),
      .step     (advance),
      .speed    (speed[i]),
      .scroll   (scroll_x[i*SCROLL_W +: SCROLL_W])
    );
  end

  // Configuration register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl       <= '0;
      key        <= '0;
      bgcol      <= '0;
      irq_period <= '0;
    end else if (bus_write) begin
      case (address)
        ADDR_CTRL:       ctrl       <= data_in[NUM_LAYERS:0];
        ADDR_KEY:        key        <= data_in[5:0];
        ADDR_BGCOL:      bgcol      <= data_in[5:0];
        ADDR_IRQ_PERIOD: irq_period <= data_in[15:0];
        default: ;
      endcase
    end
  end

  // Frame counter and interrupt flag; a new interrupt beats a same-cycle clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      if (advance)        frame_cnt <= cnt_next;
      if (irq_hit)        irq <= 1'b1;
      else if (irq_clear) irq <= 1'b0;
    end
  end

  // Vsync history used for edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      vsync_q <= vid_vsync;
      armed   <= 1'b1;
    end
  end

  // Register read mux.
  always_comb begin
    data_out = '0;
    case (address)
      ADDR_CTRL:       data_out[NUM_LAYERS:0] = ctrl;
      ADDR_STATUS:     data_out = {15'b0, irq, frame_cnt};
      ADDR_KEY:        data_out[5:0] = key;
      ADDR_BGCOL:      data_out[5:0] = bgcol;
      ADDR_IRQ_PERIOD: data_out[15:0] = irq_period;
      default: ;
    endcase
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (address == layer_addr(i)) data_out[SPEED_W-1:0] = speed[i];
    end
  end

  // Pixel priority: scan from the top layer down so the lowest index wins.
  always_comb begin
    pix_sel = bgcol;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (ctrl[CTRL_LAYER_LSB + i] && (layer_rgb[i*6 +: 6] != key)) pix_sel = layer_rgb[i*6 +: 6];
    end
    rgb_next = (vid_visible && ctrl[CTRL_EN_BIT]) ? pix_sel : '0;
  end

  // Output register with syncs delayed alongside the pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) uo_out <= '0;
    else        uo_out <= {vid_vsync, vid_hsync, rgb_next};
  end

endmodule

// File: tb/tb_tqvp_scroll_compositor.sv
// Bench for tqvp_scroll_compositor: directed scenarios then random traffic,
// all checked against a frame-level behavioural model.
module tb_tqvp_scroll_compositor;

  localparam int NL   = 3;
  localparam int SW   = 11;
  localparam int FW   = 4;
  localparam int AW   = SW + FW;
  localparam int MASK = (1 << AW) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       address = '0;
  logic [31:0]      data_in = '0;
  logic [1:0]       data_write_n = 2'b11;
  logic [1:0]       data_read_n = 2'b11;
  logic [31:0]      data_out;
  logic             data_ready;
  logic             user_interrupt;
  logic             vid_hsync = 1'b0;
  logic             vid_vsync = 1'b0;
  logic             vid_visible = 1'b0;
  logic [NL*6-1:0]  layer_rgb = '0;
  logic [NL*SW-1:0] scroll_x;
  logic [7:0]       uo_out;

  tqvp_scroll_compositor #(.NUM_LAYERS(NL), .SCROLL_W(SW), .FRAC_W(FW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt),
    .vid_hsync      (vid_hsync),
    .vid_vsync      (vid_vsync),
    .vid_visible    (vid_visible),
    .layer_rgb      (layer_rgb),
    .scroll_x       (scroll_x),
    .uo_out         (uo_out)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model state
  int m_ctrl, m_key, m_bg, m_period, m_cnt, m_irq, m_vsq, m_armed, m_uo;
  int m_speed [NL];
  int m_acc [NL];

  int n_vec = 0;
  int n_bad = 0;

  int addr_list [11] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h20, 'h24, 'h28, 'h2C, 'h3C};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 0; m_key = 0; m_bg = 0; m_period = 0; m_cnt = 0; m_irq = 0;
    m_vsq = 0; m_armed = 0; m_uo = 0;
    for (int i = 0; i < NL; i++) begin
      m_speed[i] = 0;
      m_acc[i] = 0;
    end
  endtask

  function automatic int read_model(input int a);
    if (a == 'h00) return m_ctrl;
    if (a == 'h04) return (m_irq << 16) | m_cnt;
    if (a == 'h20) return m_key;
    if (a == 'h24) return m_bg;
    if (a == 'h28) return m_period;
    for (int i = 0; i < NL; i++) if (a == 8 + 4 * i) return m_speed[i];
    return 0;
  endfunction

  function automatic int px(input int i);
    return int'(layer_rgb[i*6 +: 6]);
  endfunction

  // What one clock edge does, in terms of frames, pixels and register fields.
  task automatic model_edge();
    bit wr, frame, adv, found, set;
    int d, a, pix, s;
    wr = (data_write_n != 2'b11);
    d = data_in;
    a = int'(address);
    pix = 0;
    if (vid_visible && (m_ctrl & 1) != 0) begin
      pix = m_bg;
      found = 0;
      for (int i = 0; i < NL; i++) begin
        if (!found && ((m_ctrl >> (i + 1)) & 1) != 0 && px(i) != m_key) begin
          pix = px(i);
          found = 1;
        end
      end
    end
    frame = (m_armed != 0) && vid_vsync && (m_vsq == 0);
    adv = frame && ((m_ctrl & 1) != 0);
    for (int i = 0; i < NL; i++) begin
      s = (m_speed[i] >= 128) ? m_speed[i] - 256 : m_speed[i];
      if (wr && a == 8 + 4 * i && d[15]) m_acc[i] = 0;
      else if (adv) m_acc[i] = (m_acc[i] + s) & MASK;
    end
    set = 0;
    if (adv) begin
      m_cnt = (m_cnt + 1) & 'hFFFF;
      if (m_period != 0 && m_cnt != 0 && (m_cnt % m_period) == 0) set = 1;
    end
    if (set) m_irq = 1;
    else if (wr && a == 'h04 && d[16]) m_irq = 0;
    if (wr) begin
      if (a == 'h00) m_ctrl = d & ((1 << (NL + 1)) - 1);
      if (a == 'h20) m_key = d & 63;
      if (a == 'h24) m_bg = d & 63;
      if (a == 'h28) m_period = d & 'hFFFF;
      for (int i = 0; i < NL; i++) if (a == 8 + 4 * i) m_speed[i] = d & 255;
    end
    m_vsq = vid_vsync;
    m_armed = 1;
    m_uo = (int'(vid_vsync) << 7) | (int'(vid_hsync) << 6) | pix;
  endtask

  task automatic check_outputs();
    check_val("uo_out", 32'(uo_out), m_uo);
    for (int i = 0; i < NL; i++) check_val($sformatf("scroll_x%0d", i), 32'(scroll_x[i*SW +: SW]), m_acc[i] >> FW);
    check_val("user_interrupt", 32'(user_interrupt), m_irq);
    check_val($sformatf("data_out@%0h", address), data_out, read_model(int'(address)));
  endtask

  // One clock: DUT and model both consume the current inputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    address = a;
    data_in = d;
    data_write_n = 2'($urandom_range(0, 2));
    step();
    data_write_n = 2'b11;
  endtask

  task automatic pulse();
    vid_vsync = 1'b1;
    step();
    vid_vsync = 1'b0;
    step();
  endtask

  initial begin
    model_reset();
    address = 6'h04;
    #2;
    check_val("reset_uo", 32'(uo_out), 0);
    check_val("reset_scroll", 32'(scroll_x), 0);
    check_val("reset_irq", 32'(user_interrupt), 0);
    check_val("reset_status", data_out, 0);
    check_val("data_ready", 32'(data_ready), 1);
    #10 rst_n = 1'b1;

    // 1 px/frame for 5 frames
    bus_wr(6'h08, 32'h10);
    bus_wr(6'h00, 32'h1);
    repeat (5) pulse();
    check_val("speed_1px_5frames", 32'(scroll_x[SW-1:0]), 5);

    // -0.5 px/frame from zero wraps below 0
    bus_wr(6'h08, 32'h80F8);
    check_val("zeroed", 32'(scroll_x[SW-1:0]), 0);
    repeat (2) pulse();
    check_val("neg_wrap", 32'(scroll_x[SW-1:0]), 32'h7FF);

    // Priority with colour key
    bus_wr(6'h20, 32'h0);
    bus_wr(6'h24, 32'h2A);
    bus_wr(6'h00, 32'h7);
    vid_visible = 1'b1;
    layer_rgb = {6'h3F, 6'h15, 6'h00};
    step();
    check_val("keyed_layer1", 32'(uo_out[5:0]), 32'h15);
    layer_rgb = {6'h3F, 6'h00, 6'h00};
    step();
    check_val("backdrop", 32'(uo_out[5:0]), 32'h2A);

    // Asynchronous reset mid-stream
    address = 6'h04;
    vid_vsync = 1'b1;
    step();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_val("midreset_uo", 32'(uo_out), 0);
    check_val("midreset_scroll", 32'(scroll_x), 0);
    check_val("midreset_irq", 32'(user_interrupt), 0);
    check_val("midreset_status", data_out, 0);
    #2 rst_n = 1'b1;
    step();
    vid_vsync = 1'b0;
    step();

    // Interrupt every 3 frames, set beats clear
    bus_wr(6'h28, 32'd3);
    bus_wr(6'h00, 32'h1);
    repeat (3) pulse();
    check_val("irq_at_3", 32'(user_interrupt), 1);
    bus_wr(6'h04, 32'h10000);
    check_val("irq_cleared", 32'(user_interrupt), 0);
    repeat (2) pulse();
    vid_vsync = 1'b1;
    address = 6'h04;
    data_in = 32'h10000;
    data_write_n = 2'b00;
    step();
    data_write_n = 2'b11;
    check_val("irq_set_wins", 32'(user_interrupt), 1);
    vid_vsync = 1'b0;
    step();

    // Zero request beats a coincident frame step
    bus_wr(6'h08, 32'h10);
    repeat (2) pulse();
    check_val("pre_zero", 32'(scroll_x[SW-1:0]), 2);
    vid_vsync = 1'b1;
    address = 6'h08;
    data_in = 32'h8010;
    data_write_n = 2'b01;
    step();
    data_write_n = 2'b11;
    check_val("zero_wins", 32'(scroll_x[SW-1:0]), 0);
    vid_vsync = 1'b0;
    step();

    // Random traffic
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 5) == 0) vid_vsync = ~vid_vsync;
      vid_hsync = 1'($urandom_range(0, 1));
      vid_visible = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NL; i++) begin
        layer_rgb[i*6 +: 6] = ($urandom_range(0, 3) == 0) ? 6'(m_key) : 6'($urandom);
      end
      address = 6'(addr_list[$urandom_range(0, 10)]);
      data_in = $urandom;
      if (address == 6'h00) data_in[0] = ($urandom_range(0, 7) != 0);
      if (address == 6'h28) data_in = 32'($urandom_range(0, 6));
      if (address >= 6'h08 && address <= 6'h14) data_in[15] = ($urandom_range(0, 7) == 0);
      data_write_n = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      step();
      data_write_n = 2'b11;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
